sum_master: RTL and testbench

Requester-side controller for the registered `sum` adder. It buffers operand pairs from an upstream valid/ready stream and issues them to the adder over `sum_in1`/`sum_in2`/`sum_in_en` at up to one pair per cycle. It collects `sum_out`/`carry_bit_out` on `sum_out_en` into a result FIFO, which drains to a downstream valid/ready stream. Credit accounting guarantees that a returning result always has a free result slot.

---
 rtl/sum_master.sv | 93 +++++++++
 tb/tb_sum_master.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sum_master.sv
// sum_master: operand/result FIFOs with credit-based issue to the registered sum adder.
// Define SUM_MASTER_CARRY_CNT_EN to enable the saturating carry_cnt counter.
module sum_master #(
  parameter int BUS_WIDTH = 32,
  parameter int OP_DEPTH  = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [BUS_WIDTH-1:0] op_in1,
  input  logic [BUS_WIDTH-1:0] op_in2,
  input  logic                 op_valid,
  output logic                 op_ready,
  output logic [BUS_WIDTH-1:0] sum_in1,
  output logic [BUS_WIDTH-1:0] sum_in2,
  output logic                 sum_in_en,
  input  logic [BUS_WIDTH-1:0] sum_out,
  input  logic                 carry_bit_out,
  input  logic                 sum_out_en,
  input  logic                 ready,
  output logic [BUS_WIDTH-1:0] res_data,
  output logic                 res_carry,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 err,
  output logic [15:0]          carry_cnt
);
  localparam int OAW = $clog2(OP_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam logic [RAW+1:0] RD = (RAW+2)'(RES_DEPTH);
  logic [2*BUS_WIDTH-1:0] op_mem [OP_DEPTH];
  logic [BUS_WIDTH:0] res_mem [RES_DEPTH];
  logic [OAW:0] op_wp, op_rp;
  logic [RAW:0] res_wp, res_rp, res_count, infl;
  logic [BUS_WIDTH:0] res_head;
  logic op_full, op_empty, res_full, push, issue, res_pop, res_push, dec, err_set;
  always_comb begin
    op_empty = op_wp == op_rp;
    op_full = (op_wp[OAW] != op_rp[OAW]) && (op_wp[OAW-1:0] == op_rp[OAW-1:0]);
    res_count = res_wp - res_rp;
    res_full = res_count == RD[RAW:0];
    push = op_valid && !op_full;
    // reserve a result slot for every in-flight pair so returns can never overflow
    issue = !op_empty && ready && (({1'b0, res_count} + {1'b0, infl}) < RD);
    res_pop = res_valid && res_ready;
    dec = sum_out_en && infl != '0;
    res_push = dec && (!res_full || res_pop);
    err_set = sum_out_en && (infl == '0 || (res_full && !res_pop));
    res_head = res_mem[res_rp[RAW-1:0]];
  end
  assign op_ready = !op_full;
  assign res_valid = res_wp != res_rp;
  assign res_data = res_valid ? res_head[BUS_WIDTH-1:0] : '0;
  assign res_carry = res_valid ? res_head[BUS_WIDTH] : 1'b0;
  always_ff @(posedge clk) begin
    if (push) op_mem[op_wp[OAW-1:0]] <= {op_in1, op_in2};
    if (res_push) res_mem[res_wp[RAW-1:0]] <= {carry_bit_out, sum_out};
  end
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      op_wp <= '0;
      op_rp <= '0;
      res_wp <= '0;
      res_rp <= '0;
      infl <= '0;
      sum_in1 <= '0;
      sum_in2 <= '0;
      sum_in_en <= 1'b0;
      err <= 1'b0;
    end else begin
      if (push) op_wp <= op_wp + 1'b1;
      if (issue) begin
        op_rp <= op_rp + 1'b1;
        {sum_in1, sum_in2} <= op_mem[op_rp[OAW-1:0]];
      end
      sum_in_en <= issue;
      if (res_push) res_wp <= res_wp + 1'b1;
      if (res_pop) res_rp <= res_rp + 1'b1;
      infl <= infl + (RAW+1)'(issue) - (RAW+1)'(dec);
      err <= err | err_set;
    end
  end
`ifdef SUM_MASTER_CARRY_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) cnt <= '0;
    else if (res_push && carry_bit_out && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign carry_cnt = cnt;
`else
  assign carry_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_sum_master.sv
// tb_sum_master: directed bench for sum_master with a behavioral one-cycle registered adder.
module tb_sum_master;
  logic clk, arst;
  logic [31:0] op_in1, op_in2, sum_in1, sum_in2, sum_out, res_data;
  logic op_valid, op_ready, sum_in_en, carry_bit_out, sum_out_en, ready;
  logic res_carry, res_valid, res_ready, err, force_en, a_en;
  logic [15:0] carry_cnt;
  int checks = 0, errors = 0;
`ifdef SUM_MASTER_CARRY_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct { logic [31:0] a, b, s; logic c; } vec_t;
  vec_t vecs [6];

  sum_master #(.BUS_WIDTH(32), .OP_DEPTH(4), .RES_DEPTH(4)) dut (
    .clk(clk), .arst(arst), .op_in1(op_in1), .op_in2(op_in2), .op_valid(op_valid),
    .op_ready(op_ready), .sum_in1(sum_in1), .sum_in2(sum_in2), .sum_in_en(sum_in_en),
    .sum_out(sum_out), .carry_bit_out(carry_bit_out), .sum_out_en(sum_out_en),
    .ready(ready), .res_data(res_data), .res_carry(res_carry), .res_valid(res_valid),
    .res_ready(res_ready), .err(err), .carry_cnt(carry_cnt)
  );

  // registered adder sharing the reset
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      {carry_bit_out, sum_out} <= '0;
      a_en <= 1'b0;
    end else begin
      {carry_bit_out, sum_out} <= {1'b0, sum_in1} + {1'b0, sum_in2};
      a_en <= sum_in_en;
    end
  end
  assign sum_out_en = a_en | force_en;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_sum_in1"}, 64'(sum_in1), 0);
    check({tag, "_sum_in2"}, 64'(sum_in2), 0);
    check({tag, "_sum_in_en"}, 64'(sum_in_en), 0);
    check({tag, "_res_valid"}, 64'(res_valid), 0);
    check({tag, "_res_data"}, 64'(res_data), 0);
    check({tag, "_res_carry"}, 64'(res_carry), 0);
    check({tag, "_err"}, 64'(err), 0);
    check({tag, "_carry_cnt"}, 64'(carry_cnt), 0);
  endtask

  initial begin
    int lat, pulses, expc, acc, issues, got, n, seen_v, seen_e;
    clk = 0; arst = 1; op_valid = 0; op_in1 = 0; op_in2 = 0;
    ready = 1; res_ready = 0; force_en = 0;
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
    vecs[5] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0};
    #1 arst = 0;
    #1 reset_vals("rst");
    @(negedge clk) arst = 1;
    check("op_ready_after_rst", 64'(op_ready), 1);

    res_ready = 1; expc = 0;
    for (int v = 0; v < 6; v++) begin
      @(negedge clk); op_in1 = vecs[v].a; op_in2 = vecs[v].b; op_valid = 1;
      @(negedge clk); op_valid = 0;
      lat = 0; pulses = 0;
      while (!res_valid && lat < 20) begin
        @(negedge clk); lat++;
        if (sum_in_en) pulses++;
      end
      check("latency", 64'(lat), 3);
      check("issue_pulses", 64'(pulses), 1);
      check("res_data", 64'(res_data), 64'(vecs[v].s));
      check("res_carry", 64'(res_carry), 64'(vecs[v].c));
      if (vecs[v].c) expc++;
      @(negedge clk);
      check("popped", 64'(res_valid), 0);
      check("carry_cnt", 64'(carry_cnt), CNT_EN ? 64'(expc) : 0);
    end

    res_ready = 0; acc = 0; issues = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (sum_in_en) issues++;
      if (acc < 8 && op_ready) begin
        op_in1 = acc; op_in2 = acc + 1; op_valid = 1; acc++;
      end else op_valid = 0;
    end
    check("bp_accepted", 64'(acc), 8);
    check("bp_issues", 64'(issues), 4);
    check("bp_op_ready", 64'(op_ready), 0);
    check("bp_res_valid", 64'(res_valid), 1);
    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk); res_ready = 1;
      if (res_valid) begin
        check("bp_data", 64'(res_data), 64'(2 * got + 1));
        got++;
      end
    end
    check("bp_count", 64'(got), 8);
    check("bp_err", 64'(err), 0);

    @(negedge clk); ready = 0; op_in1 = 10; op_in2 = 20; op_valid = 1; issues = 0;
    @(negedge clk); op_in1 = 100; op_in2 = 1; issues += int'(sum_in_en);
    @(negedge clk); op_valid = 0; issues += int'(sum_in_en);
    repeat (4) begin @(negedge clk); issues += int'(sum_in_en); end
    check("nr_no_issue", 64'(issues), 0);
    ready = 1;
    @(negedge clk);
    check("nr_issue1_en", 64'(sum_in_en), 1);
    check("nr_issue1_a", 64'(sum_in1), 10);
    @(negedge clk);
    check("nr_issue2_en", 64'(sum_in_en), 1);
    check("nr_issue2_a", 64'(sum_in1), 100);
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      if (res_valid) begin
        check("nr_data", 64'(res_data), got == 0 ? 64'd30 : 64'd101);
        got++;
      end
    end
    check("nr_count", 64'(got), 2);

    repeat (2) @(negedge clk);
    force_en = 1;
    @(negedge clk); force_en = 0;
    check("spur_err", 64'(err), 1);
    check("spur_res_valid", 64'(res_valid), 0);
    repeat (3) @(negedge clk);
    check("spur_err_sticky", 64'(err), 1);
    check("spur_res_valid_later", 64'(res_valid), 0);
    arst = 0;
    #1 reset_vals("spur_rst");
    @(negedge clk) arst = 1;

    @(negedge clk); op_in1 = 7; op_in2 = 9; op_valid = 1;
    @(negedge clk); op_valid = 0;
    n = 0;
    while (!sum_in_en && n < 10) begin @(negedge clk); n++; end
    check("mf_saw_issue", 64'(sum_in_en), 1);
    arst = 0;
    #1 reset_vals("mf_rst");
    @(negedge clk) arst = 1;
    seen_v = 0; seen_e = 0;
    repeat (10) begin
      @(negedge clk);
      seen_v |= int'(res_valid);
      seen_e |= int'(sum_in_en);
    end
    check("mf_no_res_valid", 64'(seen_v), 0);
    check("mf_no_issue", 64'(seen_e), 0);
    check("mf_op_ready", 64'(op_ready), 1);
    check("mf_err", 64'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
